// File: rtl/rca4_checker.sv
// Response checker for the ripple-carry adder bench: accepts captured adder
// transactions, recomputes the golden sum in two stages and tallies errors.
module rca4_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 10,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             vld,
    output logic             rdy,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [WIDTH-1:0] Sum,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam int ACC_W = $clog2(NUM_VEC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               accept;
    logic               clear;

    logic               s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic               s1_cin_q, s1_cin_d;
    logic [WIDTH-1:0]   s1_sum_q, s1_sum_d;
    logic               s1_cout_q, s1_cout_d;
    logic [ACC_W-1:0]   s1_idx_q, s1_idx_d;

    logic [WIDTH:0]     exp_sum;
    logic               s2_vld_q, s2_vld_d;
    logic               s2_mis_q, s2_mis_d;
    logic [ACC_W-1:0]   s2_idx_q, s2_idx_d;

    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               ff_vld_q, ff_vld_d;
    logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;

    assign accept = vld && (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        rdy       = 1'b0;
        busy      = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                rdy  = 1'b1;
                busy = 1'b1;
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + ACC_W'(1);
                    if (acc_cnt_d == ACC_W'(NUM_VEC)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Golden result is formed at WIDTH+1 bits so the carry lands in the top bit.
    assign exp_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q} + (WIDTH + 1)'(s1_cin_q);

    always_comb begin
        s1_vld_d  = accept;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_cin_d  = s1_cin_q;
        s1_sum_d  = s1_sum_q;
        s1_cout_d = s1_cout_q;
        s1_idx_d  = s1_idx_q;
        if (accept) begin
            s1_a_d    = A;
            s1_b_d    = B;
            s1_cin_d  = Cin;
            s1_sum_d  = Sum;
            s1_cout_d = Cout;
            s1_idx_d  = acc_cnt_q;
        end

        s2_vld_d = s1_vld_q;
        s2_mis_d = (exp_sum != {s1_cout_q, s1_sum_q});
        s2_idx_d = s1_idx_q;

        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        ff_vld_d  = ff_vld_q;
        ff_idx_d  = ff_idx_q;
        if (clear) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            ff_vld_d  = 1'b0;
            ff_idx_d  = '0;
        end else if (s2_vld_q) begin
            if (vec_cnt_q != '1) begin
                vec_cnt_d = vec_cnt_q + CNT_W'(1);
            end
            if (s2_mis_q) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_idx_d = CNT_W'(s2_idx_q);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            acc_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_cin_q  <= 1'b0;
            s1_sum_q  <= '0;
            s1_cout_q <= 1'b0;
            s1_idx_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_mis_q  <= 1'b0;
            s2_idx_q  <= '0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            ff_vld_q  <= 1'b0;
            ff_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_cin_q  <= s1_cin_d;
            s1_sum_q  <= s1_sum_d;
            s1_cout_q <= s1_cout_d;
            s1_idx_q  <= s1_idx_d;
            s2_vld_q  <= s2_vld_d;
            s2_mis_q  <= s2_mis_d;
            s2_idx_q  <= s2_idx_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            ff_vld_q  <= ff_vld_d;
            ff_idx_q  <= ff_idx_d;
        end
    end

    assign done           = (state_q == DONE);
    assign pass           = done && (err_cnt_q == '0);
    assign vec_cnt        = vec_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;

endmodule

// File: tb/tb_rca4_checker.sv
// Directed bench for rca4_checker: three instances (nominal, 3-bit counters,
// exhaustive) share the transaction inputs; the nominal one is scoreboarded per cycle.
module tb_rca4_checker;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic       vld   = 1'b0;
    logic [3:0] a     = '0;
    logic [3:0] b     = '0;
    logic [3:0] sum   = '0;
    logic       cin   = 1'b0;
    logic       cout  = 1'b0;
    logic       m_start = 1'b0;
    logic       s_start = 1'b0;
    logic       x_start = 1'b0;

    logic        m_rdy, m_busy, m_done, m_pass, m_ffv;
    logic [15:0] m_vec, m_err, m_ffi;
    logic        s_rdy, s_busy, s_done, s_pass, s_ffv;
    logic [2:0]  s_vec, s_err, s_ffi;
    logic        x_rdy, x_busy, x_done, x_pass, x_ffv;
    logic [15:0] x_vec, x_err, x_ffi;

    always #5 Clk = ~Clk;

    rca4_checker #(.WIDTH(4), .NUM_VEC(4), .CNT_W(16)) u_main (
        .Clk(Clk), .Reset(Reset), .start(m_start), .vld(vld), .rdy(m_rdy),
        .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout),
        .busy(m_busy), .done(m_done), .pass(m_pass), .vec_cnt(m_vec), .err_cnt(m_err),
        .first_fail_vld(m_ffv), .first_fail_idx(m_ffi)
    );

    rca4_checker #(.WIDTH(4), .NUM_VEC(10), .CNT_W(3)) u_sat (
        .Clk(Clk), .Reset(Reset), .start(s_start), .vld(vld), .rdy(s_rdy),
        .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .vec_cnt(s_vec), .err_cnt(s_err),
        .first_fail_vld(s_ffv), .first_fail_idx(s_ffi)
    );

    rca4_checker #(.WIDTH(4), .NUM_VEC(512), .CNT_W(16)) u_exh (
        .Clk(Clk), .Reset(Reset), .start(x_start), .vld(vld), .rdy(x_rdy),
        .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout),
        .busy(x_busy), .done(x_done), .pass(x_pass), .vec_cnt(x_vec), .err_cnt(x_err),
        .first_fail_vld(x_ffv), .first_fail_idx(x_ffi)
    );

    typedef struct {
        int e;
        int idx;
        bit mis;
    } sb_t;

    sb_t sb[$];
    int  cyc     = 0;
    int  total   = 0;
    int  bad     = 0;
    int  acc_n   = 0;
    int  m_idx   = 0;
    int  exp_vec = 0;
    int  exp_err = 0;
    int  exp_ffi = 0;
    bit  exp_ffv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        exp_vec = 0;
        exp_err = 0;
        exp_ffv = 1'b0;
        exp_ffi = 0;
        m_idx   = 0;
        acc_n   = 0;
    endtask

    // One clock: record what u_main accepts, retire entries two edges later, check counters.
    task automatic tick();
        bit  was_acc;
        bit  mis;
        sb_t t;
        was_acc = vld && m_rdy;
        mis = (({1'b0, a} + {1'b0, b} + {4'b0, cin}) != {cout, sum});
        @(posedge Clk);
        cyc++;
        if (was_acc) begin
            sb.push_back('{cyc, m_idx, mis});
            m_idx++;
            acc_n++;
        end
        #1;
        while (sb.size() > 0 && sb[0].e + 2 <= cyc) begin
            t = sb.pop_front();
            exp_vec++;
            if (t.mis) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ffi = t.idx;
                end
            end
        end
        chk("m_vec_cnt", m_vec, exp_vec);
        chk("m_err_cnt", m_err, exp_err);
    endtask

    task automatic drive(input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                         input logic [3:0] si, input logic co);
        a    = ai;
        b    = bi;
        cin  = ci;
        sum  = si;
        cout = co;
        vld  = 1'b1;
    endtask

    task automatic drive_good(input logic [3:0] ai, input logic [3:0] bi, input logic ci);
        logic [4:0] r;
        r = {1'b0, ai} + {1'b0, bi} + {4'b0, ci};
        drive(ai, bi, ci, r[3:0], r[4]);
    endtask

    task automatic start_main();
        vld = 1'b0;
        m_start = 1'b1;
        clear_model();
        tick();
        m_start = 1'b0;
        chk("m_busy_after_start", m_busy, 1);
        chk("m_rdy_after_start", m_rdy, 1);
        chk("m_done_after_start", m_done, 0);
        chk("m_ffv_after_start", m_ffv, 0);
    endtask

    task automatic wait_m_done(output int n);
        n = 0;
        while (!m_done && n < 20) begin
            tick();
            n++;
        end
        chk("m_done_seen", m_done, 1);
    endtask

    task automatic check_main_zero(input string tag);
        chk({tag, "_rdy"}, m_rdy, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_pass"}, m_pass, 0);
        chk({tag, "_vec"}, m_vec, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_ffv"}, m_ffv, 0);
        chk({tag, "_ffi"}, m_ffi, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #2;
        check_main_zero("reset");
        chk("reset_s_vec", s_vec, 0);
        chk("reset_x_busy", x_busy, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // All-correct run with the documented vectors.
        start_main();
        drive(4'd3, 4'd5, 1'b0, 4'b1000, 1'b0);  tick();
        drive(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1); tick();
        drive(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1); tick();
        drive(4'd0, 4'd0, 1'b0, 4'b0000, 1'b0);  tick();
        vld = 1'b0;
        chk("t1_rdy_drop", m_rdy, 0);
        chk("t1_busy_drain", m_busy, 1);
        wait_m_done(n);
        chk("t1_done_latency", n, 3);
        chk("t1_vec", m_vec, 4);
        chk("t1_err", m_err, 0);
        chk("t1_pass", m_pass, 1);
        chk("t1_ffv", m_ffv, 0);
        chk("t1_busy_done", m_busy, 0);

        // Restart from DONE with a corrupted Sum on vector 2.
        start_main();
        chk("t2_vec_cleared", m_vec, 0);
        drive(4'd3, 4'd5, 1'b0, 4'b1000, 1'b0);  tick();
        drive(4'd15, 4'd1, 1'b0, 4'b0000, 1'b1); tick();
        drive(4'd15, 4'd15, 1'b1, 4'b1110, 1'b1); tick();
        drive(4'd0, 4'd0, 1'b0, 4'b0000, 1'b0);  tick();
        vld = 1'b0;
        wait_m_done(n);
        chk("t2_err", m_err, 1);
        chk("t2_ffv", m_ffv, 1);
        chk("t2_ffi", m_ffi, 2);
        chk("t2_pass", m_pass, 0);

        // Gapped valid pattern, with a start pulse inside RUN that must be ignored.
        start_main();
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) drive_good(4'(i * 3), 4'(i * 5 + 1), 1'(i));
            else vld = 1'b0;
            m_start = (i == 2);
            tick();
        end
        m_start = 1'b0;
        vld = 1'b0;
        chk("t3_accepts", acc_n, 4);
        chk("t3_rdy_after_last", m_rdy, 0);
        wait_m_done(n);
        chk("t3_vec", m_vec, 4);
        chk("t3_pass", m_pass, 1);

        // Asynchronous reset in the middle of a run, then a clean run.
        start_main();
        drive_good(4'd1, 4'd2, 1'b0); tick();
        drive_good(4'd7, 4'd8, 1'b1); tick();
        vld = 1'b0;
        tick();
        tick();
        chk("t4_pre_vec", m_vec, 2);
        chk("t4_pre_busy", m_busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        check_main_zero("t4_async");
        clear_model();
        @(negedge Clk);
        Reset = 1'b0;
        start_main();
        drive_good(4'd9, 4'd6, 1'b1);  tick();
        drive_good(4'd12, 4'd4, 1'b0); tick();
        drive_good(4'd2, 4'd13, 1'b1); tick();
        drive_good(4'd8, 4'd8, 1'b0);  tick();
        vld = 1'b0;
        wait_m_done(n);
        chk("t4_vec", m_vec, 4);
        chk("t4_err", m_err, 0);
        chk("t4_pass", m_pass, 1);

        // 3-bit counters, ten wrong vectors: both counters pin at 7.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("s_busy", s_busy, 1);
        for (int i = 0; i < 10; i++) begin
            logic [4:0] r;
            r = {1'b0, 4'(i)} + {1'b0, 4'(i + 3)} + 5'(i % 2);
            drive(4'(i), 4'(i + 3), 1'(i), r[3:0] ^ 4'h1, r[4]);
            tick();
        end
        vld = 1'b0;
        n = 0;
        while (!s_done && n < 20) begin
            tick();
            n++;
        end
        chk("s_done_seen", s_done, 1);
        chk("s_vec_sat", s_vec, 7);
        chk("s_err_sat", s_err, 7);
        chk("s_ffv", s_ffv, 1);
        chk("s_ffi", s_ffi, 0);
        chk("s_pass", s_pass, 0);

        // Exhaustive correct run over all A/B/Cin.
        x_start = 1'b1;
        tick();
        x_start = 1'b0;
        for (int i = 0; i < 512; i++) begin
            drive_good(4'(i), 4'(i >> 4), 1'(i >> 8));
            tick();
        end
        vld = 1'b0;
        n = 0;
        while (!x_done && n < 20) begin
            tick();
            n++;
        end
        chk("x_done_seen", x_done, 1);
        chk("x_vec", x_vec, 512);
        chk("x_err", x_err, 0);
        chk("x_ffv", x_ffv, 0);
        chk("x_pass", x_pass, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
